vram_access_arbiter: RTL and testbench
======================================

// Module: vram_access_arbiter
// PURPOSE
//  Arbitrates three requesters for the single port of the terminal character RAM:
//  req[0] video scan-out fetch, req[1] CPU/PIA display write, req[2] clear-screen sweep.
//  Scan-out has strict priority; CPU and clear-screen alternate round-robin.
//  Sequences each access (enable, address, data, read capture) and returns a one-cycle ack.
// PARAMETERS
//  ADDR_W         10  character RAM address width (40x24 = 960 cells)
//  DATA_W          6  character code width
//  ACCESS_CYCLES   2  cycles the RAM port is owned per access; min 2 (1-cycle-latency sync RAM)
// PORTS
//  clk        in   1              system clock; all state on rising edge
//  rst_n      in   1              asynchronous, active-low reset
//  req        in   3              access request per requester, level, held until ack
//  req_we     in   3              1 = write, 0 = read, per requester
//  req_addr   in   3*ADDR_W       requester i at [i*ADDR_W +: ADDR_W]
//  req_wdata  in   3*DATA_W       requester i at [i*DATA_W +: DATA_W]
//  grant      out  3              one-hot owner of the RAM port, registered
//  ack        out  3              one-cycle completion pulse to the owner
//  rdata      out  DATA_W         read data, valid while ack is high, held until next read
//  busy       out  1              OR of grant bits
//  ram_en     out  1              RAM port enable, one cycle per access
//  ram_we     out  1              RAM write enable, qualified by ram_en
//  ram_addr   out  ADDR_W         RAM address
//  ram_wdata  out  DATA_W         RAM write data
//  ram_rdata  in   DATA_W         RAM read data, valid the cycle after ram_en
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; grant, ack, busy, ram_en, ram_we = 0; ram_addr, ram_wdata,
//   rdata = 0; rr pointer = 1 (requester 1 wins the first 1-vs-2 contest). Reset mid-access aborts
//   with no ack; RAM write already issued is not undone.
//  States: IDLE -> ACCESS -> DONE -> IDLE.
//  IDLE: winner = req[0] ? 0 : (req[1]&req[2]) ? rr : req[1] ? 1 : req[2] ? 2 : none.
//   On edge with winner: grant<=onehot(winner); latch we/addr/wdata of winner onto ram_*;
//   ram_en<=1; cnt<=ACCESS_CYCLES-1; -> ACCESS. If winner is 1 or 2, rr <= the other one.
//   rr is unchanged when requester 0 is served.
//  ACCESS: ram_en high only in the first ACCESS cycle; ram_addr/ram_wdata/ram_we stable throughout.
//   cnt decrements; at cnt==0: if read, rdata<=ram_rdata; ack<=grant; -> DONE.
//  DONE: ack high exactly this cycle, grant still held; next edge grant<=0, ack<=0 -> IDLE.
//  Latency: req sampled at edge k -> grant/ram_en visible after k, ack after k+ACCESS_CYCLES,
//   grant drops after k+ACCESS_CYCLES+1. Back-to-back turnaround = ACCESS_CYCLES+2 cycles.
//  Requester inputs are sampled only at the IDLE->ACCESS edge; later changes are ignored.
//  Requester must drop req the cycle after ack, otherwise it is re-arbitrated as a new request.
//  Non-preemptive: req[0] arriving during ACCESS/DONE waits until IDLE, then wins over 1/2.
//  req dropped mid-access: access completes, ack still pulses.
//  Continuous req[0] starves 1 and 2; accepted, scan-out duty is bounded by the video timing.
//  Exactly one grant bit set in ACCESS/DONE, none in IDLE; ack is always a subset of grant.
// STRUCTURE
//  Shared package terminal_pkg: REQ_SCAN=0, REQ_CPU=1, REQ_CLR=2, state encoding IDLE/ACCESS/DONE.
//  Single flat module, no sub-modules: winner select is a small combinational function,
//   the rest is one state register, one counter, and the output registers.
// TESTING
//  1 Reset: hold rst_n=0 with req=3'b111 -> grant=0, ack=0, ram_en=0, rdata=0. Release -> first grant 3'b001.
//  2 Write: req[1], we=1, addr=10'h123, wdata=6'h15 -> ram_en one cycle with addr 123/we=1/wdata 15;
//    ack[1] 2 cycles later; grant 010 for 3 cycles.
//  3 Read: preload RAM[10'h3BF]=6'h2A; req[0] read -> ack[0] pulse with rdata=2A, held after ack.
//  4 Round-robin: req[1]&req[2] held continuously -> grant order 010,100,010,100; a req[0] pulse
//    between them does not disturb the alternation.
//  5 Priority/non-preempt: req[0] rises during a req[2] ACCESS -> req[2] still acks;
//    next grant is 001 although req[1] is also pending.
//  6 Reset mid-access: rst_n low during ACCESS -> immediate IDLE outputs, no ack; after release,
//    the request is re-arbitrated.

Source files
------------

// File: rtl/terminal_pkg.sv
`default_nettype none
// ============================================================================
// Module      : terminal_pkg
// Description : Shared definitions for the terminal video/character RAM path.
//               Requester indices for the character RAM arbiter and the
//               arbiter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package terminal_pkg;

  // Requester slots on the character RAM arbiter
  localparam logic [1:0] REQ_SCAN = 2'd0;  // video scan-out fetch
  localparam logic [1:0] REQ_CPU  = 2'd1;  // CPU/PIA display write
  localparam logic [1:0] REQ_CLR  = 2'd2;  // clear-screen sweep

  localparam int NUM_REQ = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/vram_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vram_access_arbiter
// Description : Three-way arbiter for the single port of the terminal
//               character RAM. Scan-out (req[0]) has strict priority; CPU
//               (req[1]) and clear-screen (req[2]) alternate round-robin.
//               Each access owns the RAM port for ACCESS_CYCLES cycles and
//               finishes with a one-cycle ack to the owner.
// Ports       : clk, rst_n               clock, async active-low reset
//               req/req_we/req_addr/req_wdata   packed per-requester inputs
//               grant, ack, busy         ownership / completion status
//               rdata                    captured read data (held)
//               ram_en/ram_we/ram_addr/ram_wdata/ram_rdata  RAM port
// Revision    : 1.0 - initial release
// ============================================================================
module vram_access_arbiter
  import terminal_pkg::*;
#(
  parameter int ADDR_W        = 10,
  parameter int DATA_W        = 6,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2:0]            req,
  input  logic [2:0]            req_we,
  input  logic [3*ADDR_W-1:0]   req_addr,
  input  logic [3*DATA_W-1:0]   req_wdata,
  output logic [2:0]            grant,
  output logic [2:0]            ack,
  output logic [DATA_W-1:0]     rdata,
  output logic                  busy,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_wdata,
  input  logic [DATA_W-1:0]     ram_rdata
);

  // Counter holds values ACCESS_CYCLES-1 .. 0
  localparam int CNT_W = $clog2(ACCESS_CYCLES);
  localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(ACCESS_CYCLES - 1);

  arb_state_t          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [1:0]          r_rr;        // which of CPU/CLR wins the next tie
  logic [2:0]          r_grant;
  logic [2:0]          r_ack;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_ram_en;
  logic                r_ram_we;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [DATA_W-1:0]   r_ram_wdata;

  logic [2:0]          w_win;
  logic                w_sel_we;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;

  // One-hot winner: scan-out first, then round-robin between CPU and clear.
  function automatic logic [2:0] pick_winner(input logic [2:0] r, input logic [1:0] rr);
    logic [2:0] oh;
    oh = 3'b000;
    if (r[REQ_SCAN])
      oh[REQ_SCAN] = 1'b1;
    else if (r[REQ_CPU] && r[REQ_CLR])
      oh[rr] = 1'b1;
    else if (r[REQ_CPU])
      oh[REQ_CPU] = 1'b1;
    else if (r[REQ_CLR])
      oh[REQ_CLR] = 1'b1;
    return oh;
  endfunction

  assign w_win = pick_winner(req, r_rr);

  // Select the winner's access fields
  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win[i]) begin
        w_sel_we    = req_we[i];
        w_sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        w_sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_rr        <= REQ_CPU;
      r_grant     <= 3'b000;
      r_ack       <= 3'b000;
      r_rdata     <= '0;
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_win) begin
            r_grant     <= w_win;
            r_ram_en    <= 1'b1;
            r_ram_we    <= w_sel_we;
            r_ram_addr  <= w_sel_addr;
            r_ram_wdata <= w_sel_wdata;
            r_cnt       <= c_cnt_load;
            r_state     <= ACCESS;
            // Serving one of the pair hands the next tie to the other;
            // scan-out service leaves the pointer alone.
            if (w_win[REQ_CPU])
              r_rr <= REQ_CLR;
            else if (w_win[REQ_CLR])
              r_rr <= REQ_CPU;
          end
        end

        ACCESS: begin
          r_ram_en <= 1'b0;
          if (r_cnt == '0) begin
            if (!r_ram_we)
              r_rdata <= ram_rdata;
            r_ack   <= r_grant;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        DONE: begin
          r_grant <= 3'b000;
          r_ack   <= 3'b000;
          r_state <= IDLE;
        end

        default: begin
          r_grant  <= 3'b000;
          r_ack    <= 3'b000;
          r_ram_en <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

  assign grant     = r_grant;
  assign ack       = r_ack;
  assign rdata     = r_rdata;
  assign busy      = |r_grant;
  assign ram_en    = r_ram_en;
  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;

endmodule
`default_nettype wire

// File: tb/tb_vram_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vram_access_arbiter
// Description : Directed self-checking bench for vram_access_arbiter with a
//               1-cycle-latency synchronous character RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vram_access_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 6;

  logic                clk;
  logic                rst_n;
  logic [2:0]          req;
  logic [2:0]          req_we;
  logic [3*ADDR_W-1:0] req_addr;
  logic [3*DATA_W-1:0] req_wdata;
  logic [2:0]          grant;
  logic [2:0]          ack;
  logic [DATA_W-1:0]   rdata;
  logic                busy;
  logic                ram_en;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_addr;
  logic [DATA_W-1:0]   ram_wdata;
  logic [DATA_W-1:0]   ram_rdata;

  // RAM model with a bench-side preload port
  logic [DATA_W-1:0]   mem [0:1023];
  logic                pre_en;
  logic [ADDR_W-1:0]   pre_addr;
  logic [DATA_W-1:0]   pre_data;

  int n_checks;
  int n_errors;

  vram_access_arbiter #(
    .ADDR_W        (ADDR_W),
    .DATA_W        (DATA_W),
    .ACCESS_CYCLES (2)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .grant     (grant),
    .ack       (ack),
    .rdata     (rdata),
    .busy      (busy),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_en) begin
      mem[pre_addr] <= pre_data;
    end else if (ram_en) begin
      if (ram_we)
        mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance n rising edges, landing 1 time unit after the last one
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_slot(input int slot, input logic we, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d);
    req_we[slot]                    = we;
    req_addr[slot*ADDR_W +: ADDR_W] = a;
    req_wdata[slot*DATA_W +: DATA_W] = d;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    req       = 3'b111;
    req_we    = 3'b000;
    req_addr  = '0;
    req_wdata = '0;
    pre_en    = 1'b0;
    pre_addr  = '0;
    pre_data  = '0;
    ram_rdata = '0;

    // ---- 1: reset with all requests asserted
    step(3);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_ack",   32'(ack),   32'h0);
    check("rst_ram_en", 32'(ram_en), 32'h0);
    check("rst_rdata", 32'(rdata), 32'h0);
    check("rst_busy",  32'(busy),  32'h0);
    rst_n = 1'b1;
    step(1);
    check("first_grant", 32'(grant), 32'h1);
    check("first_ram_en", 32'(ram_en), 32'h1);
    req = 3'b000;                    // dropped mid-access: ack must still come
    step(1);
    check("first_en_drop", 32'(ram_en), 32'h0);
    step(1);
    check("first_ack", 32'(ack), 32'h1);
    step(1);
    check("first_idle", 32'(grant), 32'h0);

    // ---- 2: CPU write
    set_slot(1, 1'b1, 10'h123, 6'h15);
    req = 3'b010;
    step(1);
    check("wr_grant", 32'(grant), 32'h2);
    check("wr_en",    32'(ram_en), 32'h1);
    check("wr_we",    32'(ram_we), 32'h1);
    check("wr_addr",  32'(ram_addr), 32'h123);
    check("wr_wdata", 32'(ram_wdata), 32'h15);
    check("wr_busy",  32'(busy), 32'h1);
    check("wr_ack0",  32'(ack), 32'h0);
    step(1);
    check("wr_en_off", 32'(ram_en), 32'h0);
    check("wr_addr_hold", 32'(ram_addr), 32'h123);
    check("wr_ack1", 32'(ack), 32'h0);
    step(1);
    check("wr_ack", 32'(ack), 32'h2);
    check("wr_grant_done", 32'(grant), 32'h2);
    check("wr_mem", 32'(mem[10'h123]), 32'h15);
    req = 3'b000;
    step(1);
    check("wr_grant_off", 32'(grant), 32'h0);
    check("wr_ack_off", 32'(ack), 32'h0);

    // ---- 3: scan-out read
    pre_en = 1'b1; pre_addr = 10'h3BF; pre_data = 6'h2A;
    step(1);
    pre_en = 1'b0;
    set_slot(0, 1'b0, 10'h3BF, 6'h00);
    req = 3'b001;
    step(1);
    check("rd_grant", 32'(grant), 32'h1);
    check("rd_we",    32'(ram_we), 32'h0);
    check("rd_addr",  32'(ram_addr), 32'h3BF);
    step(2);
    check("rd_ack",   32'(ack), 32'h1);
    check("rd_data",  32'(rdata), 32'h2A);
    req = 3'b000;
    step(2);
    check("rd_hold",  32'(rdata), 32'h2A);
    check("rd_idle",  32'(grant), 32'h0);

    // ---- 4: round-robin after a fresh reset (pointer starts at CPU)
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    set_slot(1, 1'b0, 10'h010, 6'h00);
    set_slot(2, 1'b0, 10'h020, 6'h00);
    req = 3'b110;
    step(1);
    check("rr_g1", 32'(grant), 32'h2);
    step(2);
    check("rr_ack1", 32'(ack), 32'h2);
    step(2);
    check("rr_g2", 32'(grant), 32'h4);
    req = 3'b111;                    // scan-out pulse arrives mid-access
    step(4);
    check("rr_scan", 32'(grant), 32'h1);
    req = 3'b110;
    step(4);
    check("rr_g3", 32'(grant), 32'h2);
    step(4);
    check("rr_g4", 32'(grant), 32'h4);
    req = 3'b000;
    step(3);
    check("rr_idle", 32'(grant), 32'h0);

    // ---- 5: priority without preemption
    req = 3'b100;
    step(1);
    check("pri_clr", 32'(grant), 32'h4);
    req = 3'b111;
    step(1);
    check("pri_hold", 32'(grant), 32'h4);
    step(1);
    check("pri_clr_ack", 32'(ack), 32'h4);
    req = 3'b011;
    step(1);
    check("pri_idle", 32'(grant), 32'h0);
    step(1);
    check("pri_scan", 32'(grant), 32'h1);
    req = 3'b010;
    step(2);
    check("pri_scan_ack", 32'(ack), 32'h1);
    step(2);
    check("pri_cpu", 32'(grant), 32'h2);
    req = 3'b000;
    step(3);

    // ---- 6: reset during access
    set_slot(1, 1'b1, 10'h055, 6'h3C);
    req = 3'b010;
    step(1);
    check("mr_grant", 32'(grant), 32'h2);
    #1 rst_n = 1'b0;
    #1;
    check("mr_grant_rst", 32'(grant), 32'h0);
    check("mr_en_rst", 32'(ram_en), 32'h0);
    check("mr_busy_rst", 32'(busy), 32'h0);
    check("mr_rdata_rst", 32'(rdata), 32'h0);
    step(2);
    check("mr_no_ack", 32'(ack), 32'h0);
    rst_n = 1'b1;
    step(1);
    check("mr_regrant", 32'(grant), 32'h2);
    check("mr_addr", 32'(ram_addr), 32'h055);
    step(2);
    check("mr_ack", 32'(ack), 32'h2);
    req = 3'b000;
    step(1);
    check("mr_idle", 32'(grant), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
